inst_bus_if: RTL and testbench
==============================

// Module: inst_bus_if
// PURPOSE
//  IF-stage instruction bus master, directly downstream of the PC register.
//  - Takes the fetch address pc_i and enable ce_i, and runs a req/ack handshake to an instruction memory with variable latency.
//  - Returns the instruction word to the IF/ID register on inst_o.
//  - Raises stallreq_o to CTRL so the PC and IF/ID hold while a fetch is outstanding.
// PARAMETERS
//  TIMEOUT_CYCLES  255  max BUSY cycles before abort (used only with INST_BUS_TIMEOUT_EN)
//  CNT_W           8    width of timeout counter; must satisfy 2**CNT_W > TIMEOUT_CYCLES
// PORTS
//  clk          in   1   clock, all state updates on posedge
//  rst          in   1   reset, synchronous, active-high
//  pc_i         in   32  fetch address from PC register
//  ce_i         in   1   fetch enable from PC register (1 = fetch)
//  stall_i      in   6   CTRL stall vector; bit0 = PC stage held
//  flush_i      in   1   CTRL flush; discard current/outstanding fetch
//  mem_addr_o   out  32  instruction memory address (= pc_i)
//  mem_req_o    out  1   memory request, held until ack
//  mem_ack_i    in   1   memory ack; mem_rdata_i valid this cycle
//  mem_rdata_i  in   32  memory read data
//  inst_o       out  32  instruction to IF/ID
//  stallreq_o   out  1   stall request to CTRL
//  bus_err_o    out  1   one-cycle pulse on fetch timeout
// BEHAVIOUR
//  Reset: state=IDLE; inst buffer=0; counter=0; bus_err_o=0.
//   Outputs in reset: mem_req_o=0, stallreq_o=0, inst_o=0.
//  States: IDLE, BUSY, HOLD, DRAIN.
//  Handshake: transfer when mem_req_o & mem_ack_i in the same cycle.
//   mem_addr_o must stay stable while mem_req_o=1; the PC is held by stallreq_o.
//   mem_ack_i is ignored when mem_req_o=0.
//  IDLE:
//   - mem_req_o = ce_i & ~flush_i.
//   - Zero-wait ack in the same cycle is legal: inst_o=mem_rdata_i, stallreq_o=0.
//   - No ack: stallreq_o=ce_i & ~flush_i, next state BUSY.
//   - On any transfer: buffer<=mem_rdata_i; next state HOLD if stall_i[0]=1, else IDLE.
//  BUSY:
//   - mem_req_o=1, stallreq_o=1, inst_o=0 (NOP bubble).
//   - On ack: inst_o=mem_rdata_i combinationally, stallreq_o=0.
//     Next state HOLD if stall_i[0]=1, else IDLE.
//  HOLD:
//   - mem_req_o=0, stallreq_o=0, inst_o=buffer.
//   - Exit to IDLE at the first edge with stall_i[0]=0.
//  Flush:
//   - IDLE/HOLD with flush_i=1: next IDLE; inst_o=0 that cycle; no request issued.
//   - BUSY with flush_i=1: next DRAIN; the outstanding request is not withdrawn.
//  DRAIN:
//   - mem_req_o=1 until ack; ack data discarded; inst_o=0; stallreq_o=1.
//   - On ack: next IDLE.
//  Simultaneous flush_i and ack in BUSY: data discarded, next IDLE.
//  ce_i=0: no request, stallreq_o=0, inst_o=0.
//  rst mid-fetch: immediate IDLE; a late ack after reset is ignored (req=0).
//  Latency: 0 extra cycles with zero-wait memory; otherwise N wait cycles = N stall cycles.
// CONFIGURATION
//  INST_BUS_TIMEOUT_EN defined:
//   - Counter increments each BUSY/DRAIN cycle; cleared on leaving the state.
//   - When counter reaches TIMEOUT_CYCLES without ack:
//     mem_req_o drops, bus_err_o pulses 1 cycle, inst_o=0, stallreq_o=0 that cycle.
//     Next state HOLD if stall_i[0]=1, else IDLE.
//  INST_BUS_TIMEOUT_EN undefined: no counter; waits indefinitely; bus_err_o tied 0.
// TESTING
//  1. Zero-wait ack, pc 0x0,0x4,0x8, data 0x34011100.. -> inst_o matches each cycle, stallreq_o never 1.
//  2. 3-wait memory at pc=0x10 -> stallreq_o=1 for 3 cycles, inst_o=0, then 0x8C220004 with stallreq_o=0.
//  3. Ack while stall_i=6'b000111 for 2 cycles -> HOLD, inst_o stays 0xACDE0008, no new req, resumes after.
//  4. flush_i in BUSY at pc=0x20, ack 2 cycles later -> DRAIN, data dropped, inst_o=0, next req uses new pc.
//  5. rst asserted in BUSY, then ack -> mem_req_o=0, inst_o=0, state IDLE, ack ignored.
//  6. INST_BUS_TIMEOUT_EN, TIMEOUT_CYCLES=4, no ack -> bus_err_o pulse after 4 BUSY cycles, req drops.

Source files
------------

// File: rtl/inst_bus_if.sv
// IF-stage instruction bus master: req/ack fetch from variable-latency memory, stalls the PC while busy.
// Optional fetch timeout enabled by defining INST_BUS_TIMEOUT_EN.
module inst_bus_if #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_i,
  input  logic        ce_i,
  input  logic [5:0]  stall_i,
  input  logic        flush_i,
  output logic [31:0] mem_addr_o,
  output logic        mem_req_o,
  input  logic        mem_ack_i,
  input  logic [31:0] mem_rdata_i,
  output logic [31:0] inst_o,
  output logic        stallreq_o,
  output logic        bus_err_o
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_BUSY  = 2'd1;
  localparam logic [1:0] S_HOLD  = 2'd2;
  localparam logic [1:0] S_DRAIN = 2'd3;

  if (2 ** CNT_W <= TIMEOUT_CYCLES) begin : g_cfg_check
    $error("inst_bus_if: CNT_W too small for TIMEOUT_CYCLES");
  end

  logic [1:0]  r_state;
  logic [1:0]  w_state_next;
  logic [31:0] r_buf;
  logic [31:0] r_addr;
  logic        w_req;
  logic        w_load;
  logic        w_timeout;
  logic        w_unused_stall;

  // Only the PC-stage bit of the CTRL stall vector matters here.
  assign w_unused_stall = ^stall_i[5:1];

`ifdef INST_BUS_TIMEOUT_EN
  logic [CNT_W-1:0] r_cnt;

  assign w_timeout = ((r_state == S_BUSY) || (r_state == S_DRAIN)) &&
                     (r_cnt == CNT_W'(TIMEOUT_CYCLES));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (((r_state == S_BUSY) || (r_state == S_DRAIN)) && (w_state_next == r_state)) begin
      r_cnt <= r_cnt + 1'b1;
    end else begin
      r_cnt <= '0;
    end
  end
`else
  assign w_timeout = 1'b0;
`endif

  always_comb begin
    w_req        = 1'b0;
    w_load       = 1'b0;
    stallreq_o   = 1'b0;
    inst_o       = 32'h0;
    mem_addr_o   = pc_i;
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        w_req      = ce_i & ~flush_i;
        stallreq_o = w_req & ~mem_ack_i;
        if (w_req && mem_ack_i) begin
          inst_o       = mem_rdata_i;
          w_load       = 1'b1;
          w_state_next = stall_i[0] ? S_HOLD : S_IDLE;
        end else if (w_req) begin
          w_state_next = S_BUSY;
        end
      end
      S_BUSY: begin
        mem_addr_o = r_addr;
        if (w_timeout) begin
          w_state_next = (stall_i[0] && !flush_i) ? S_HOLD : S_IDLE;
        end else begin
          w_req = 1'b1;
          if (mem_ack_i) begin
            if (flush_i) begin
              w_state_next = S_IDLE;
            end else begin
              inst_o       = mem_rdata_i;
              w_load       = 1'b1;
              w_state_next = stall_i[0] ? S_HOLD : S_IDLE;
            end
          end else begin
            stallreq_o   = 1'b1;
            w_state_next = flush_i ? S_DRAIN : S_BUSY;
          end
        end
      end
      S_HOLD: begin
        if (flush_i) begin
          w_state_next = S_IDLE;
        end else begin
          inst_o       = r_buf;
          w_state_next = stall_i[0] ? S_HOLD : S_IDLE;
        end
      end
      default: begin
        mem_addr_o = r_addr;
        if (w_timeout) begin
          w_state_next = S_IDLE;
        end else begin
          w_req      = 1'b1;
          stallreq_o = 1'b1;
          if (mem_ack_i) begin
            w_state_next = S_IDLE;
          end
        end
      end
    endcase
    // Reset silences the bus immediately so a late ack is never accepted.
    if (rst) begin
      w_req        = 1'b0;
      w_load       = 1'b0;
      stallreq_o   = 1'b0;
      inst_o       = 32'h0;
      w_state_next = S_IDLE;
    end
  end

  assign mem_req_o = w_req;
  assign bus_err_o = w_timeout & ~rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_buf   <= 32'h0;
      r_addr  <= 32'h0;
    end else begin
      r_state <= w_state_next;
      // A timed-out fetch parks a NOP so a following HOLD replays a bubble, not stale code.
      if (w_timeout) begin
        r_buf <= 32'h0;
      end else if (w_load) begin
        r_buf <= mem_rdata_i;
      end
      if ((r_state == S_IDLE) && w_req && !mem_ack_i) begin
        r_addr <= pc_i;
      end
    end
  end

endmodule

// File: tb/tb_inst_bus_if.sv
// Directed scoreboard bench for inst_bus_if: driver queues expected per-cycle outputs, monitor checks them.
module tb_inst_bus_if;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] pc_i = 32'h0;
  logic        ce_i = 1'b0;
  logic [5:0]  stall_i = 6'h0;
  logic        flush_i = 1'b0;
  logic [31:0] mem_addr_o;
  logic        mem_req_o;
  logic        mem_ack_i = 1'b0;
  logic [31:0] mem_rdata_i = 32'h0;
  logic [31:0] inst_o;
  logic        stallreq_o;
  logic        bus_err_o;

  always #5 clk = ~clk;

  inst_bus_if #(.TIMEOUT_CYCLES(4), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .pc_i(pc_i), .ce_i(ce_i), .stall_i(stall_i), .flush_i(flush_i),
    .mem_addr_o(mem_addr_o), .mem_req_o(mem_req_o), .mem_ack_i(mem_ack_i),
    .mem_rdata_i(mem_rdata_i), .inst_o(inst_o), .stallreq_o(stallreq_o), .bus_err_o(bus_err_o)
  );

  typedef struct {
    string       name;
    logic        req;
    logic        stl;
    logic        err;
    logic [31:0] inst;
    logic [31:0] addr;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic cyc(input string name, input logic r, input logic ce, input logic [31:0] pc,
                     input logic [5:0] st, input logic fl, input logic ack, input logic [31:0] rd,
                     input logic e_req, input logic e_stl, input logic [31:0] e_inst,
                     input logic e_err);
    exp_t e;
    @(posedge clk);
    #1;
    rst = r; ce_i = ce; pc_i = pc; stall_i = st; flush_i = fl; mem_ack_i = ack; mem_rdata_i = rd;
    e.name = name; e.req = e_req; e.stl = e_stl; e.err = e_err; e.inst = e_inst; e.addr = pc;
    q.push_back(e);
  endtask

  // Same as cyc but the expected bus address differs from the current pc (outstanding fetch).
  task automatic cyc_a(input string name, input logic ce, input logic [31:0] pc, input logic fl,
                       input logic ack, input logic [31:0] rd, input logic e_stl,
                       input logic [31:0] e_addr);
    exp_t e;
    @(posedge clk);
    #1;
    rst = 1'b0; ce_i = ce; pc_i = pc; stall_i = 6'h0; flush_i = fl; mem_ack_i = ack; mem_rdata_i = rd;
    e.name = name; e.req = 1'b1; e.stl = e_stl; e.err = 1'b0; e.inst = 32'h0; e.addr = e_addr;
    q.push_back(e);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        $display("txn %s req=%0b stall=%0b err=%0b inst=%08h addr=%08h",
                 e.name, mem_req_o, stallreq_o, bus_err_o, inst_o, mem_addr_o);
        checks++;
        if ({mem_req_o, stallreq_o, bus_err_o, inst_o} !== {e.req, e.stl, e.err, e.inst}) begin
          errors++;
          $display("FAIL %s: got req=%0b stall=%0b err=%0b inst=%08h, want req=%0b stall=%0b err=%0b inst=%08h",
                   e.name, mem_req_o, stallreq_o, bus_err_o, inst_o, e.req, e.stl, e.err, e.inst);
        end
        if (e.req) begin
          checks++;
          if (mem_addr_o !== e.addr) begin
            errors++;
            $display("FAIL %s_addr: got %08h want %08h", e.name, mem_addr_o, e.addr);
          end
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    //  name        rst ce  pc       stall  fl ack rdata          req stl inst           err
    cyc("rst_a",    1, 1, 32'h00, 6'h0, 0, 1, 32'h12345678, 0, 0, 32'h0,         0);
    cyc("rst_b",    1, 1, 32'h00, 6'h0, 0, 1, 32'h12345678, 0, 0, 32'h0,         0);
    // zero-wait fetches
    cyc("zw_0",     0, 1, 32'h00, 6'h0, 0, 1, 32'h34011100, 1, 0, 32'h34011100,  0);
    cyc("zw_4",     0, 1, 32'h04, 6'h0, 0, 1, 32'h34021104, 1, 0, 32'h34021104,  0);
    cyc("zw_8",     0, 1, 32'h08, 6'h0, 0, 1, 32'h34031108, 1, 0, 32'h34031108,  0);
    // three wait cycles
    cyc("w3_idle",  0, 1, 32'h10, 6'h0, 0, 0, 32'hFFFFFFFF, 1, 1, 32'h0,         0);
    cyc("w3_b1",    0, 1, 32'h10, 6'h0, 0, 0, 32'hFFFFFFFF, 1, 1, 32'h0,         0);
    cyc("w3_b2",    0, 1, 32'h10, 6'h0, 0, 0, 32'hFFFFFFFF, 1, 1, 32'h0,         0);
    cyc("w3_ack",   0, 1, 32'h10, 6'h0, 0, 1, 32'h8C220004, 1, 0, 32'h8C220004,  0);
    cyc("ce_off",   0, 0, 32'h14, 6'h0, 0, 1, 32'hFFFFFFFF, 0, 0, 32'h0,         0);
    // ack under stall -> HOLD replays buffer
    cyc("hold_ack", 0, 1, 32'h14, 6'h07, 0, 1, 32'hACDE0008, 1, 0, 32'hACDE0008, 0);
    cyc("hold_1",   0, 1, 32'h14, 6'h07, 0, 1, 32'hBAD0BAD0, 0, 0, 32'hACDE0008, 0);
    cyc("hold_2",   0, 1, 32'h14, 6'h00, 0, 1, 32'hBAD0BAD0, 0, 0, 32'hACDE0008, 0);
    cyc("resume",   0, 1, 32'h18, 6'h00, 0, 1, 32'h11111111, 1, 0, 32'h11111111, 0);
    // flush in BUSY -> DRAIN
    cyc("fl_idle",  0, 1, 32'h20, 6'h0, 0, 0, 32'h0,        1, 1, 32'h0,         0);
    cyc("fl_busy",  0, 1, 32'h20, 6'h0, 1, 0, 32'h0,        1, 1, 32'h0,         0);
    cyc_a("drain_w",   1, 32'h40, 0, 0, 32'h0,        1, 32'h20);
    cyc_a("drain_ack", 1, 32'h40, 0, 1, 32'hDEADBEEF, 1, 32'h20);
    cyc("new_pc",   0, 1, 32'h40, 6'h0, 0, 1, 32'h22222222, 1, 0, 32'h22222222, 0);
    // flush together with ack in BUSY
    cyc("fa_idle",  0, 1, 32'h44, 6'h0, 0, 0, 32'h0,        1, 1, 32'h0,         0);
    cyc("fa_both",  0, 1, 32'h44, 6'h0, 1, 1, 32'h33333333, 1, 0, 32'h0,         0);
    // flush in IDLE and in HOLD
    cyc("fl_idle2", 0, 1, 32'h48, 6'h0, 1, 1, 32'h99999999, 0, 0, 32'h0,         0);
    cyc("h_enter",  0, 1, 32'h48, 6'h07, 0, 1, 32'h44444444, 1, 0, 32'h44444444, 0);
    cyc("h_flush",  0, 1, 32'h4C, 6'h07, 1, 0, 32'h0,        0, 0, 32'h0,         0);
    cyc("h_after",  0, 0, 32'h4C, 6'h00, 0, 0, 32'h0,        0, 0, 32'h0,         0);
    // reset mid-fetch, late ack ignored
    cyc("r_idle",   0, 1, 32'h50, 6'h0, 0, 0, 32'h0,        1, 1, 32'h0,         0);
    cyc("r_busy",   1, 1, 32'h50, 6'h0, 0, 1, 32'h55555555, 0, 0, 32'h0,         0);
    cyc("r_late",   0, 0, 32'h50, 6'h0, 0, 1, 32'h55555555, 0, 0, 32'h0,         0);
    cyc("r_next",   0, 1, 32'h54, 6'h0, 0, 1, 32'h66666666, 1, 0, 32'h66666666, 0);
`ifdef INST_BUS_TIMEOUT_EN
    cyc("to_idle",  0, 1, 32'h60, 6'h0, 0, 0, 32'h0,        1, 1, 32'h0,         0);
    for (int i = 0; i < 4; i++)
      cyc("to_busy", 0, 1, 32'h60, 6'h0, 0, 0, 32'h0,       1, 1, 32'h0,         0);
    cyc("to_fire",  0, 1, 32'h60, 6'h0, 0, 0, 32'h0,        0, 0, 32'h0,         1);
    cyc("to_after", 0, 0, 32'h60, 6'h0, 0, 0, 32'h0,        0, 0, 32'h0,         0);
`else
    cyc("lw_idle",  0, 1, 32'h60, 6'h0, 0, 0, 32'h0,        1, 1, 32'h0,         0);
    for (int i = 0; i < 6; i++)
      cyc("lw_busy", 0, 1, 32'h60, 6'h0, 0, 0, 32'h0,       1, 1, 32'h0,         0);
    cyc("lw_ack",   0, 1, 32'h60, 6'h0, 0, 1, 32'h77777777, 1, 0, 32'h77777777, 0);
`endif
    cyc("end",      0, 0, 32'h0,  6'h0, 0, 0, 32'h0,        0, 0, 32'h0,         0);
    @(posedge clk);
    @(negedge clk);
    #1;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain_queue: got %0d pending want 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
